// File: rtl/cla_pkg.sv
// Shared definitions for the group-serial adder: FSM state encoding and
// the default number of bits added per cycle.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GROUPSIZE_DEFAULT = 4;

endpackage

// File: rtl/group_add.sv
// Combinational W-bit group adder. Besides the sum and carry out it reports
// the carry into the group's MSB, which the top uses for signed overflow.
module group_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s     = total[W-1:0];
  assign cout  = total[W];
  // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
  assign cmsb  = s[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/group_serial_adder.sv
// Group-serial adder/subtractor: adds GROUPSIZE bits per cycle, LSB group
// first, taking WIDTH/GROUPSIZE cycles per operation. Subtraction folds into
// addition by inverting b and forcing the carry-in to 1.
// Optional feature: define GROUP_SERIAL_OVERFLOW_EN to add the signed
// overflow output.
module group_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = GROUPSIZE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef GROUP_SERIAL_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             cout
);

  localparam int N     = WIDTH / GROUPSIZE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if ((WIDTH % GROUPSIZE) != 0) begin : g_bad_width
    $error("group_serial_adder: WIDTH must be a multiple of GROUPSIZE");
  end

  state_t               state;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic                 carry;
  logic [IDX_W-1:0]     idx;
  logic [GROUPSIZE-1:0] ga;
  logic [GROUPSIZE-1:0] gb;
  logic [GROUPSIZE-1:0] gs;
  logic                 gcout;
  logic                 gcmsb;

  assign ga = a_r[idx*GROUPSIZE +: GROUPSIZE];
  assign gb = b_r[idx*GROUPSIZE +: GROUPSIZE];

  group_add #(.W(GROUPSIZE)) u_group_add (
    .a    (ga),
    .b    (gb),
    .cin  (carry),
    .s    (gs),
    .cout (gcout),
    .cmsb (gcmsb)
  );

`ifndef GROUP_SERIAL_OVERFLOW_EN
  logic unused_cmsb;
  assign unused_cmsb = gcmsb;
`endif

  // Control FSM plus group datapath; handshake outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
`ifdef GROUP_SERIAL_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b ^ {WIDTH{sub}};
            carry    <= sub | cin;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          sum[idx*GROUPSIZE +: GROUPSIZE] <= gs;
          carry <= gcout;
          if (idx == LAST) begin
            cout      <= gcout;
`ifdef GROUP_SERIAL_OVERFLOW_EN
            overflow  <= gcmsb ^ gcout;
`endif
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
